// File: rtl/ext_pipe_if.sv
// Handshake bundle for ext_pipe: producer side (imm/EOp/in_tag) and consumer side (ext/out_tag/out_err).
// The master modport belongs to whoever drives the requests; slave is the ext_pipe view.
interface ext_pipe_if #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32,
  parameter int TAG_W = 5
);
  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  imm;
  logic [2:0]       EOp;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] ext;
  logic [TAG_W-1:0] out_tag;
  logic             out_err;

  modport master (
    output in_valid, imm, EOp, in_tag, out_ready,
    input  in_ready, out_valid, ext, out_tag, out_err
  );

  modport slave (
    input  in_valid, imm, EOp, in_tag, out_ready,
    output in_ready, out_valid, ext, out_tag, out_err
  );
endinterface

// File: rtl/ext_pipe.sv
// Handshaked immediate extender with a DEPTH-entry result FIFO between decode and operand select.
// Optional macro EXT_ILLEGAL_DROP_EN: illegal opcodes are consumed but never enqueued, out_err stays 0.
module ext_pipe #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32,
  parameter int TAG_W = 5,
  parameter int DEPTH = 2
) (
  input  logic      clk,
  input  logic      reset,
  ext_pipe_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [OUT_W-1:0] ext;
    logic [TAG_W-1:0] tag;
    logic             err;
  } entry_t;

  entry_t           mem [DEPTH];
  entry_t           new_entry;
  entry_t           head;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic [OUT_W-1:0] sext;
  logic             illegal;
  logic             push;
  logic             pop;
  logic             wr_en;

  // Ready depends only on registered count, so a full buffer refuses a push even while popping.
  assign bus.in_ready  = (count < CNT_W'(DEPTH));
  assign bus.out_valid = (count != '0);
  assign push          = bus.in_valid && bus.in_ready;
  assign pop           = bus.out_valid && bus.out_ready;

  // NOTE: every always_comb output gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    sext          = {{(OUT_W-IN_W){bus.imm[IN_W-1]}}, bus.imm};
    new_entry     = '0;
    new_entry.tag = bus.in_tag;
    illegal       = 1'b0;
    case (bus.EOp)
      3'b000:  new_entry.ext = sext;
      3'b001:  new_entry.ext = {{(OUT_W-IN_W){1'b0}}, bus.imm};
      3'b010:  new_entry.ext = {bus.imm, {(OUT_W-IN_W){1'b0}}};
      3'b011:  new_entry.ext = {sext[OUT_W-3:0], 2'b00};
      3'b100:  new_entry.ext = {{(OUT_W-8){bus.imm[7]}}, bus.imm[7:0]};
      default: illegal = 1'b1;
    endcase
`ifdef EXT_ILLEGAL_DROP_EN
    new_entry.err = 1'b0;
`else
    new_entry.err = illegal;
`endif
  end

`ifdef EXT_ILLEGAL_DROP_EN
  assign wr_en = push && !illegal;
`else
  assign wr_en = push;
`endif

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)   rd_ptr <= rd_ptr + PTR_W'(1);
      case ({wr_en, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // NOTE: the storage array is deliberately not reset; count gates its visibility, so contents are don't-care.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= new_entry;
  end

  assign head        = mem[rd_ptr];
  assign bus.ext     = bus.out_valid ? head.ext : '0;
  assign bus.out_tag = bus.out_valid ? head.tag : '0;
  assign bus.out_err = bus.out_valid ? head.err : 1'b0;
endmodule
